// File: rtl/memio_pkg.sv
// LC-3 memory / memory-mapped I/O shared definitions.
// Device register map, controller states and the bus-error read value.
package memio_pkg;

  localparam logic [15:0] DEV_BASE  = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

  localparam logic [15:0] BUS_ERR_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    DONE     = 2'd2
  } memio_state_e;

  function automatic logic is_dev(input logic [15:0] addr);
    return addr >= DEV_BASE;
  endfunction

endpackage

// File: rtl/memio_dev_regs.sv
// LC-3 device registers: KBSR/KBDR, DSR/DDR, MCR with keyboard and
// display handshakes; single-edge access strobed by the controller.
module memio_dev_regs
  import memio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [1:0]  wdata_hi,
  input  logic [7:0]  wdata_lo,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  input  logic        ddr_ready,
  output logic [15:0] rdata,
  output logic        ddr_valid,
  output logic [7:0]  ddr_data,
  output logic        kb_int,
  output logic        run
);

  logic       kb_rdy;
  logic       kb_ie;
  logic [7:0] kbdr;
  logic       mcr_run;

  logic sel_kbsr;
  logic sel_kbdr;
  logic sel_dsr;
  logic sel_ddr;
  logic sel_mcr;
  logic rd;
  logic wr;

  assign sel_kbsr = addr == KBSR_ADDR;
  assign sel_kbdr = addr == KBDR_ADDR;
  assign sel_dsr  = addr == DSR_ADDR;
  assign sel_ddr  = addr == DDR_ADDR;
  assign sel_mcr  = addr == MCR_ADDR;

  assign rd = acc & ~we;
  assign wr = acc & we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_rdy    <= 1'b0;
      kb_ie     <= 1'b0;
      kbdr      <= 8'h00;
      ddr_valid <= 1'b0;
      ddr_data  <= 8'h00;
      mcr_run   <= 1'b1;
    end else begin
      // a KBDR read beats an arriving character, which is then lost
      if (rd && sel_kbdr) begin
        kb_rdy <= 1'b0;
      end else if (kb_valid && !kb_rdy) begin
        kb_rdy <= 1'b1;
        kbdr   <= kb_data;
      end
      if (wr && sel_kbsr) begin
        kb_ie <= wdata_hi[0];
      end
      if (wr && sel_ddr) begin
        ddr_data  <= wdata_lo;
        ddr_valid <= 1'b1;
      end else if (ddr_valid && ddr_ready) begin
        ddr_valid <= 1'b0;
      end
      if (wr && sel_mcr) begin
        mcr_run <= wdata_hi[1];
      end
    end
  end

  always_comb begin
    rdata = 16'h0000;
    unique case (1'b1)
      sel_kbsr: rdata = {kb_rdy, kb_ie, 14'h0};
      sel_kbdr: rdata = {8'h00, kbdr};
      sel_dsr:  rdata = {~ddr_valid, 15'h0};
      sel_ddr:  rdata = {8'h00, ddr_data};
      sel_mcr:  rdata = {mcr_run, 15'h0};
      default:  rdata = 16'h0000;
    endcase
  end

  assign kb_int = kb_rdy & kb_ie;
  assign run    = mcr_run;

endmodule

// File: rtl/memory_io.sv
// LC-3 MAR/MDR access controller: external memory port plus device regs.
// Define MEMIO_ACCESS_TIMEOUT_EN to abort stalled memory accesses.
module memory_io
  import memio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_MIO_EN,
  input  logic        i_R_W,
  input  logic [15:0] i_MAR,
  input  logic [15:0] i_MDR,
  output logic        o_R_Bit,
  output logic [15:0] o_MemData,
  output logic        o_MemReq,
  output logic        o_MemWe,
  output logic [15:0] o_MemAddr,
  output logic [15:0] o_MemWData,
  input  logic        i_MemAck,
  input  logic [15:0] i_MemRData,
  input  logic        i_KB_Valid,
  input  logic [7:0]  i_KB_Data,
  output logic        o_DDR_Valid,
  output logic [7:0]  o_DDR_Data,
  input  logic        i_DDR_Ready,
  output logic        o_KB_INT,
  output logic        o_Run,
  output logic        o_BusErr
);

  memio_state_e state_q;
  memio_state_e state_d;

  logic        start;
  logic        dev_hit;
  logic        dev_acc;
  logic        mem_end;
  logic        timeout;
  logic [15:0] dev_rdata;

  assign start   = (state_q == IDLE) & i_MIO_EN;
  assign dev_hit = is_dev(i_MAR);
  assign dev_acc = start & dev_hit;
  assign mem_end = (state_q == MEM_WAIT) & (i_MemAck | timeout);

  memio_dev_regs u_dev_regs (
    .clk       (i_Clk),
    .rst_n     (i_Rst_n),
    .acc       (dev_acc),
    .we        (i_R_W),
    .addr      (i_MAR),
    .wdata_hi  (i_MDR[15:14]),
    .wdata_lo  (i_MDR[7:0]),
    .kb_valid  (i_KB_Valid),
    .kb_data   (i_KB_Data),
    .ddr_ready (i_DDR_Ready),
    .rdata     (dev_rdata),
    .ddr_valid (o_DDR_Valid),
    .ddr_data  (o_DDR_Data),
    .kb_int    (o_KB_INT),
    .run       (o_Run)
  );

`ifdef MEMIO_ACCESS_TIMEOUT_EN
  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic          bus_err_q;

  assign timeout = (state_q == MEM_WAIT) & ~i_MemAck &
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == MEM_WAIT) ? cnt_q + CW'(1) : '0;
      bus_err_q <= timeout;
    end
  end

  assign o_BusErr = bus_err_q;
`else
  assign timeout  = 1'b0;
  assign o_BusErr = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = dev_hit ? DONE : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (i_MemAck || timeout) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_R_Bit = state_q == DONE;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_MemData  <= 16'h0000;
      o_MemReq   <= 1'b0;
      o_MemWe    <= 1'b0;
      o_MemAddr  <= 16'h0000;
      o_MemWData <= 16'h0000;
    end else begin
      if (start) begin
        if (dev_hit) begin
          if (!i_R_W) begin
            o_MemData <= dev_rdata;
          end
        end else begin
          o_MemReq   <= 1'b1;
          o_MemWe    <= i_R_W;
          o_MemAddr  <= i_MAR;
          o_MemWData <= i_MDR;
        end
      end
      // o_MemWe still holds the direction of the finishing access
      if (mem_end) begin
        o_MemReq <= 1'b0;
        o_MemWe  <= 1'b0;
        if (!o_MemWe) begin
          o_MemData <= i_MemAck ? i_MemRData : BUS_ERR_DATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_io.sv
// Scoreboard bench for memory_io: memory port, device registers,
// back-to-back requests, reset and (when compiled in) timeout.
module tb_memory_io;

  localparam logic [15:0] A_KBSR = 16'hFE00;
  localparam logic [15:0] A_KBDR = 16'hFE02;
  localparam logic [15:0] A_DSR  = 16'hFE04;
  localparam logic [15:0] A_DDR  = 16'hFE06;
  localparam logic [15:0] A_MCR  = 16'hFFFE;
  localparam logic [62:0] RST_VEC =
    {1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
     1'b0, 8'h0, 1'b1, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mio_en = 1'b0;
  logic        r_w = 1'b0;
  logic [15:0] mar = 16'h0;
  logic [15:0] mdr = 16'h0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = 8'h0;
  logic        ddr_ready = 1'b0;

  logic        o_R_Bit;
  logic [15:0] o_MemData;
  logic        o_MemReq;
  logic        o_MemWe;
  logic [15:0] o_MemAddr;
  logic [15:0] o_MemWData;
  logic        o_DDR_Valid;
  logic [7:0]  o_DDR_Data;
  logic        o_KB_INT;
  logic        o_Run;
  logic        o_BusErr;

  int nerr = 0;
  int nchk = 0;
  logic [15:0] sb[$];
  logic [15:0] md_model = 16'h0;
  bit          kb_with_req = 1'b0;
  logic [7:0]  kb_req_data = 8'h0;

  wire [62:0] out_vec = {o_R_Bit, o_MemData, o_MemReq, o_MemWe,
    o_MemAddr, o_MemWData, o_DDR_Valid, o_DDR_Data,
    o_Run, o_KB_INT, o_BusErr};

  always #5 clk = ~clk;

  memory_io #(.TIMEOUT_CYCLES(4)) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_MIO_EN    (mio_en),
    .i_R_W       (r_w),
    .i_MAR       (mar),
    .i_MDR       (mdr),
    .o_R_Bit     (o_R_Bit),
    .o_MemData   (o_MemData),
    .o_MemReq    (o_MemReq),
    .o_MemWe     (o_MemWe),
    .o_MemAddr   (o_MemAddr),
    .o_MemWData  (o_MemWData),
    .i_MemAck    (mem_ack),
    .i_MemRData  (mem_rdata),
    .i_KB_Valid  (kb_valid),
    .i_KB_Data   (kb_data),
    .o_DDR_Valid (o_DDR_Valid),
    .o_DDR_Data  (o_DDR_Data),
    .i_DDR_Ready (ddr_ready),
    .o_KB_INT    (o_KB_INT),
    .o_Run       (o_Run),
    .o_BusErr    (o_BusErr)
  );

  // ack_after < 0 means never acknowledge
  task automatic access(input logic w, input logic [15:0] a,
                        input logic [15:0] d, input int ack_after,
                        input logic [15:0] rd, input logic [15:0] exp_rd,
                        input int exp_lat);
    logic [15:0] exp;
    logic [15:0] want;
    int reqc;
    int lat;
    bit done;
    exp = w ? md_model : exp_rd;
    if (!w) md_model = exp_rd;
    @(negedge clk);
    mio_en = 1'b1; r_w = w; mar = a; mdr = d;
    kb_valid = kb_with_req; kb_data = kb_req_data;
    sb.push_back(exp);
    @(negedge clk);
    mio_en = 1'b0; r_w = ~w; mar = a ^ 16'h00F0; mdr = ~d;
    kb_valid = 1'b0;
    reqc = 0; lat = -1; done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      mem_ack = 1'b0; mem_rdata = 16'h0;
      if (o_MemReq) begin
        reqc++;
        nchk++;
        if (o_MemAddr !== a || o_MemWe !== w ||
            (w && o_MemWData !== d)) begin
          nerr++;
          $display("FAIL mem_port a=%h we=%b wd=%h want a=%h we=%b wd=%h",
                   o_MemAddr, o_MemWe, o_MemWData, a, w, d);
        end
        if (ack_after >= 0 && reqc == ack_after + 1) begin
          mem_ack = 1'b1; mem_rdata = rd;
        end
      end
      if (o_R_Bit) begin
        done = 1'b1; lat = t;
      end else begin
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    want = sb.pop_front();
    nchk++;
    if (lat !== exp_lat) begin
      nerr++;
      $display("FAIL latency addr=%h got=%0d want=%0d", a, lat, exp_lat);
    end
    nchk++;
    if (o_MemData !== want) begin
      nerr++;
      $display("FAIL mem_data addr=%h got=%h want=%h", a, o_MemData, want);
    end
    nchk++;
    if (o_BusErr !== (ack_after < 0)) begin
      nerr++;
      $display("FAIL bus_err addr=%h got=%b want=%b", a, o_BusErr,
               ack_after < 0);
    end
    @(negedge clk);
    nchk++;
    if (o_R_Bit !== 1'b0 || o_BusErr !== 1'b0) begin
      nerr++;
      $display("FAIL r_pulse addr=%h r=%b be=%b want 0 0", a, o_R_Bit,
               o_BusErr);
    end
  endtask

  task automatic kb_strobe(input logic [7:0] c);
    @(negedge clk);
    kb_valid = 1'b1; kb_data = c;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nchk++;
    if (out_vec !== RST_VEC) begin
      nerr++;
      $display("FAIL reset_state got=%h want=%h", out_vec, RST_VEC);
    end
  endtask

  task automatic test_mem_read;
    access(1'b0, 16'h3000, 16'h0, 3, 16'h1234, 16'h1234, 4);
    access(1'b0, 16'h3002, 16'h0, 0, 16'hCAFE, 16'hCAFE, 1);
    access(1'b0, 16'hFDFE, 16'h0, 1, 16'h0F0F, 16'h0F0F, 2);
  endtask

  task automatic test_mem_write;
    access(1'b1, 16'h4000, 16'hBEEF, 2, 16'h9999, 16'h0, 3);
  endtask

  task automatic test_keyboard;
    kb_strobe(8'h41);
    access(1'b0, A_KBSR, 16'h0, 0, 16'h0, 16'h8000, 0);
    nchk++;
    if (o_KB_INT !== 1'b0) begin
      nerr++;
      $display("FAIL kb_int_off got=%b want=0", o_KB_INT);
    end
    access(1'b1, A_KBSR, 16'h4000, 0, 16'h0, 16'h0, 0);
    nchk++;
    if (o_KB_INT !== 1'b1) begin
      nerr++;
      $display("FAIL kb_int_on got=%b want=1", o_KB_INT);
    end
    access(1'b0, A_KBSR, 16'h0, 0, 16'h0, 16'hC000, 0);
    access(1'b0, A_KBDR, 16'h0, 0, 16'h0, 16'h0041, 0);
    nchk++;
    if (o_KB_INT !== 1'b0) begin
      nerr++;
      $display("FAIL kb_int_clear got=%b want=0", o_KB_INT);
    end
    access(1'b0, A_KBSR, 16'h0, 0, 16'h0, 16'h4000, 0);
    kb_strobe(8'h42);
    kb_strobe(8'h43);
    access(1'b0, A_KBDR, 16'h0, 0, 16'h0, 16'h0042, 0);
    kb_strobe(8'h44);
    kb_with_req = 1'b1; kb_req_data = 8'h45;
    access(1'b0, A_KBDR, 16'h0, 0, 16'h0, 16'h0044, 0);
    kb_with_req = 1'b0;
    access(1'b0, A_KBSR, 16'h0, 0, 16'h0, 16'h4000, 0);
    access(1'b0, A_KBDR, 16'h0, 0, 16'h0, 16'h0044, 0);
    access(1'b1, A_KBSR, 16'h0000, 0, 16'h0, 16'h0, 0);
  endtask

  task automatic test_display;
    ddr_ready = 1'b0;
    access(1'b1, A_DDR, 16'h0058, 0, 16'h0, 16'h0, 0);
    nchk++;
    if (o_DDR_Valid !== 1'b1 || o_DDR_Data !== 8'h58) begin
      nerr++;
      $display("FAIL ddr_load v=%b d=%h want 1 58", o_DDR_Valid,
               o_DDR_Data);
    end
    access(1'b0, A_DSR, 16'h0, 0, 16'h0, 16'h0000, 0);
    repeat (3) @(negedge clk);
    access(1'b1, A_DDR, 16'h0059, 0, 16'h0, 16'h0, 0);
    nchk++;
    if (o_DDR_Valid !== 1'b1 || o_DDR_Data !== 8'h59) begin
      nerr++;
      $display("FAIL ddr_overwrite v=%b d=%h want 1 59", o_DDR_Valid,
               o_DDR_Data);
    end
    ddr_ready = 1'b1;
    @(negedge clk);
    ddr_ready = 1'b0;
    nchk++;
    if (o_DDR_Valid !== 1'b0) begin
      nerr++;
      $display("FAIL ddr_accept v=%b want 0", o_DDR_Valid);
    end
    access(1'b0, A_DSR, 16'h0, 0, 16'h0, 16'h8000, 0);
  endtask

  task automatic test_mcr;
    access(1'b0, A_MCR, 16'h0, 0, 16'h0, 16'h8000, 0);
    access(1'b1, A_MCR, 16'h0000, 0, 16'h0, 16'h0, 0);
    nchk++;
    if (o_Run !== 1'b0) begin
      nerr++;
      $display("FAIL run_clear got=%b want=0", o_Run);
    end
    access(1'b0, A_MCR, 16'h0, 0, 16'h0, 16'h0000, 0);
    access(1'b1, 16'hFE08, 16'hFFFF, 0, 16'h0, 16'h0, 0);
    access(1'b0, 16'hFE08, 16'h0, 0, 16'h0, 16'h0000, 0);
    access(1'b0, A_MCR, 16'h0, 0, 16'h0, 16'h0000, 0);
    access(1'b1, A_MCR, 16'h8000, 0, 16'h0, 16'h0, 0);
    nchk++;
    if (o_Run !== 1'b1) begin
      nerr++;
      $display("FAIL run_set got=%b want=1", o_Run);
    end
  endtask

  task automatic test_back_to_back;
    int rcount;
    int first_t;
    int second_t;
    logic [15:0] want;
    rcount = 0; first_t = -1; second_t = -1;
    md_model = 16'h5000 ^ 16'hA5A5;
    @(negedge clk);
    mio_en = 1'b1; r_w = 1'b0; mar = 16'h5000;
    sb.push_back(md_model);
    sb.push_back(md_model);
    @(negedge clk);
    for (int t = 0; t < 50 && rcount < 2; t++) begin
      mem_ack = 1'b0; mem_rdata = 16'h0;
      if (o_MemReq) begin
        mem_ack = 1'b1; mem_rdata = o_MemAddr ^ 16'hA5A5;
      end
      if (o_R_Bit) begin
        rcount++;
        want = sb.pop_front();
        nchk++;
        if (o_MemData !== want) begin
          nerr++;
          $display("FAIL b2b_data got=%h want=%h", o_MemData, want);
        end
        if (rcount == 1) first_t = t;
        else begin
          second_t = t;
          mio_en = 1'b0;
        end
      end
      if (rcount < 2) @(negedge clk);
    end
    mem_ack = 1'b0; mio_en = 1'b0;
    sb.delete();
    nchk++;
    if (first_t !== 1 || second_t !== 4) begin
      nerr++;
      $display("FAIL b2b_timing got=%0d,%0d want=1,4", first_t, second_t);
    end
    @(negedge clk);
    nchk++;
    if (o_R_Bit !== 1'b0 || o_MemReq !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_stop r=%b req=%b want 0 0", o_R_Bit, o_MemReq);
    end
  endtask

`ifdef MEMIO_ACCESS_TIMEOUT_EN
  task automatic test_timeout;
    access(1'b0, 16'h7000, 16'h0, -1, 16'h0, 16'hDEAD, 4);
    access(1'b0, 16'h7002, 16'h0, 1, 16'h2222, 16'h2222, 2);
  endtask
`endif

  task automatic test_reset_mid_access;
    access(1'b1, A_MCR, 16'h0000, 0, 16'h0, 16'h0, 0);
    access(1'b1, A_DDR, 16'h0033, 0, 16'h0, 16'h0, 0);
    @(negedge clk);
    mio_en = 1'b1; r_w = 1'b0; mar = 16'h6000;
    @(negedge clk);
    mio_en = 1'b0;
    @(negedge clk);
    nchk++;
    if (o_MemReq !== 1'b1) begin
      nerr++;
      $display("FAIL mid_req got=%b want=1", o_MemReq);
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if (out_vec !== RST_VEC) begin
      nerr++;
      $display("FAIL mid_reset got=%h want=%h", out_vec, RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    md_model = 16'h0;
    access(1'b0, 16'h3000, 16'h0, 0, 16'h1111, 16'h1111, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_keyboard();
    test_display();
    test_mcr();
    test_back_to_back();
`ifdef MEMIO_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
